// File: rtl/nice_requant_pack.sv
// nice_requant_pack: int32 accumulator requantization to int8 with 4-lane word packing.
// Three-stage pipeline (bias/shift, Q31 multiply, rounding/offset/clamp) feeding a byte packer.
module nice_requant_pack #(
  parameter int ADDR_W = 13
) (
  input  logic              nice_clk,
  input  logic              nice_rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_acc,
  input  logic [31:0]       in_bias,
  input  logic [31:0]       in_mult,
  input  logic [5:0]        in_shift,
  input  logic              in_last,
  input  logic [31:0]       dst_offset,
  input  logic [31:0]       act_min,
  input  logic [31:0]       act_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_bmask,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_word_idx,
  output logic              busy
);
  typedef struct packed {
    logic              s1_v;
    logic [31:0]       s1_y;
    logic [31:0]       s1_m;
    logic [4:0]        s1_r;
    logic              s1_l;
    logic              s2_v;
    logic [31:0]       s2_dh;
    logic [4:0]        s2_r;
    logic              s2_l;
    logic              s3_v;
    logic [7:0]        s3_b;
    logic              s3_l;
    logic [1:0]        cnt;
    logic [31:0]       data;
    logic [3:0]        bmask;
    logic              ov;
    logic              olast;
    logic [ADDR_W-1:0] idx;
  } st_t;
  st_t st_d, st_q;
  logic en, done;
  logic [31:0] x, dh, msk, rem, thr, ash, q, v;
  logic [7:0] c;
  logic [4:0] sl, sr;
  logic signed [63:0] p, s;
  always_comb begin
    en = !(st_q.ov && !out_ready);
    x = in_acc + in_bias;
    sl = in_shift[5] ? 5'd0 : in_shift[4:0];
    sr = in_shift[5] ? 5'(-in_shift) : 5'd0;
    p = $signed({{32{st_q.s1_y[31]}}, st_q.s1_y}) * $signed({{32{st_q.s1_m[31]}}, st_q.s1_m});
    s = p + (p[63] ? -64'sd1073741823 : 64'sd1073741824);
    // divide by 2^31 truncating toward zero: bias negatives before the arithmetic shift
    dh = (st_q.s1_y == 32'h80000000 && st_q.s1_m == 32'h80000000) ? 32'h7fffffff :
         32'((s + (s[63] ? 64'sd2147483647 : 64'sd0)) >>> 31);
    msk = (32'd1 << st_q.s2_r) - 32'd1;
    rem = st_q.s2_dh & msk;
    thr = (msk >> 1) + {31'd0, st_q.s2_dh[31]};
    ash = $signed(st_q.s2_dh) >>> st_q.s2_r;
    q = ash + {31'd0, rem > thr};
    v = q + dst_offset;
    c = ($signed(v) < $signed(act_min)) ? act_min[7:0] :
        ($signed(v) > $signed(act_max)) ? act_max[7:0] : v[7:0];
    st_d = st_q;
    done = 1'b0;
    if (en) begin
      st_d.s1_v  = in_valid;
      st_d.s1_y  = x << sl;
      st_d.s1_m  = in_mult;
      st_d.s1_r  = sr;
      st_d.s1_l  = in_last;
      st_d.s2_v  = st_q.s1_v;
      st_d.s2_dh = dh;
      st_d.s2_r  = st_q.s1_r;
      st_d.s2_l  = st_q.s1_l;
      st_d.s3_v  = st_q.s2_v;
      st_d.s3_b  = c;
      st_d.s3_l  = st_q.s2_l;
      if (st_q.ov) begin
        st_d.ov    = 1'b0;
        st_d.olast = 1'b0;
        st_d.data  = '0;
        st_d.bmask = '0;
        st_d.idx   = st_q.olast ? '0 : st_q.idx + ADDR_W'(1);
      end
      // a byte arriving during the handshake lands in lane 0 of a fresh word
      if (st_q.s3_v) begin
        done       = st_q.cnt == 2'd3 || st_q.s3_l;
        st_d.data  = st_d.data | ({24'd0, st_q.s3_b} << {st_q.cnt, 3'd0});
        st_d.bmask = st_d.bmask | (4'd1 << st_q.cnt);
        st_d.cnt   = done ? 2'd0 : st_q.cnt + 2'd1;
        st_d.ov    = done;
        st_d.olast = st_q.s3_l;
      end
    end
    if (clear) st_d = '0;
  end
  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) st_q <= '0;
    else             st_q <= st_d;
  end
  assign in_ready     = en;
  assign out_valid    = st_q.ov;
  assign out_data     = st_q.data;
  assign out_bmask    = st_q.bmask;
  assign out_last     = st_q.olast;
  assign out_word_idx = st_q.idx;
  assign busy         = st_q.s1_v | st_q.s2_v | st_q.s3_v | (st_q.cnt != 2'd0) | st_q.ov;
endmodule

// File: tb/tb_nice_requant_pack.sv
// tb_nice_requant_pack: vector table, hand-written packing/backpressure/clear sequences,
// and randomized streams scored against an arithmetic reference model.
module tb_nice_requant_pack;
  localparam int AW = 13;
  logic clk = 0, rst_n = 1, clear = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic in_ready, out_valid, out_last, busy;
  logic [31:0] in_acc = 0, in_bias = 0, in_mult = 0, dst_offset = 0, act_min = 0, act_max = 0;
  logic [31:0] out_data;
  logic [5:0] in_shift = 0;
  logic [3:0] out_bmask;
  logic [AW-1:0] out_word_idx;

  typedef struct {logic [31:0] d; logic [3:0] m; logic l; logic [AW-1:0] i;} word_t;
  typedef struct {int acc, bias, mult, sh, off, mn, mx; logic [7:0] exp;} vec_t;
  word_t exp_q[$], got_q[$];
  int checks = 0, failures = 0, mcnt = 0;
  logic [31:0] mdata = 0;
  logic [3:0] mmask = 0;
  logic [AW-1:0] wi = 0;
  bit accepted;

  nice_requant_pack #(.ADDR_W(AW)) dut (
    .nice_clk(clk), .nice_rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_bias(in_bias),
    .in_mult(in_mult), .in_shift(in_shift), .in_last(in_last),
    .dst_offset(dst_offset), .act_min(act_min), .act_max(act_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bmask(out_bmask), .out_last(out_last), .out_word_idx(out_word_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Requantization from its arithmetic definition: Q31 doubling-high multiply,
  // then divide by 2^r rounding half away from zero, offset, clamp.
  function automatic logic [7:0] ref_byte(int acc, int bias, int mult, int sh, int off, int mn, int mx);
    int x, y, v, r;
    longint p, n, dh, a, q;
    x = acc + bias;
    r = sh < 0 ? -sh : 0;
    y = x << (sh > 0 ? sh : 0);
    p = longint'(y) * longint'(mult);
    n = p >= 0 ? (longint'(1) << 30) : 1 - (longint'(1) << 30);
    if (y == 32'sh80000000 && mult == 32'sh80000000) dh = 2147483647;
    else dh = (p + n) / (longint'(1) << 31);
    if (r == 0) q = dh;
    else begin
      a = dh < 0 ? -dh : dh;
      a = (a + (longint'(1) << (r - 1))) >> r;
      q = dh < 0 ? -a : a;
    end
    v = int'(q) + off;
    v = v < mn ? mn : (v > mx ? mx : v);
    return v[7:0];
  endfunction

  task automatic model_push();
    logic [7:0] b;
    b = ref_byte(in_acc, in_bias, in_mult, int'($signed(in_shift)), dst_offset, act_min, act_max);
    mdata |= {24'd0, b} << (8 * mcnt);
    mmask |= 4'(1 << mcnt);
    mcnt++;
    if (mcnt == 4 || in_last) begin
      exp_q.push_back('{mdata, mmask, in_last, wi});
      wi = in_last ? '0 : wi + AW'(1);
      mcnt = 0;
      mdata = 0;
      mmask = 0;
    end
  endtask

  // One clock: observe at the falling edge, then return 1ns after the rising edge.
  task automatic tick();
    word_t w, e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (clear || !rst_n) begin
      exp_q.delete();
      mcnt = 0; mdata = 0; mmask = 0; wi = 0;
    end else begin
      if (in_valid && in_ready) model_push();
      if (out_valid && out_ready) begin
        w = '{out_data, out_bmask, out_last, out_word_idx};
        got_q.push_back(w);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra: got word %h with no word expected", w.d);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", w.d, e.d);
          chk("sb_bmask", w.m, e.m);
          chk("sb_last", w.l, e.l);
          chk("sb_idx", w.i, e.i);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int off, int mn, int mx);
    dst_offset = off; act_min = mn; act_max = mx;
  endtask

  task automatic elem(int acc, logic last);
    in_acc = acc; in_bias = 0; in_mult = 32'h7fffffff; in_shift = 0; in_last = last;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0;
    out_ready = 1;
    while (busy && n < 60) begin tick(); n++; end
    chk("drain_idle", busy, 0);
  endtask

  vec_t tbl[10];
  logic [31:0] hold;
  int n, i, bad, base;
  bit have, stalled;

  initial begin
    tbl[0] = '{100, 0, 32'h40000000, 0, 0, -128, 127, 8'h32};
    tbl[1] = '{-3, 0, 32'h40000000, 0, 0, -128, 127, 8'hff};
    tbl[2] = '{1000, 0, 32'h7fffffff, -2, 0, -1024, 1023, 8'hfa};
    tbl[3] = '{1002, 0, 32'h7fffffff, -2, 0, -1024, 1023, 8'hfb};
    tbl[4] = '{500, 0, 32'h7fffffff, 0, -128, -128, 127, 8'h7f};
    tbl[5] = '{-500, 0, 32'h7fffffff, 0, -128, -128, 127, 8'h80};
    tbl[6] = '{32'h80000000, 0, 32'h80000000, 0, 0, 32'h80000000, 32'h7fffffff, 8'hff};
    tbl[7] = '{3, 0, 32'h40000000, 4, 0, -128, 127, 8'h18};
    tbl[8] = '{-6, 0, 32'h7fffffff, -2, 0, -128, 127, 8'hfe};
    tbl[9] = '{10, 20, 32'h7fffffff, 0, 5, -128, 127, 8'h23};

    #1 rst_n = 0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_idx", out_word_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;

    foreach (tbl[k]) begin
      cfg(tbl[k].off, tbl[k].mn, tbl[k].mx);
      in_acc = tbl[k].acc; in_bias = tbl[k].bias; in_mult = tbl[k].mult;
      in_shift = 6'(tbl[k].sh); in_last = 1; in_valid = 1;
      tick();
      chk("vec_accept", accepted, 1);
      in_valid = 0;
      n = 0;
      while (!out_valid && n < 10) begin tick(); n++; end
      chk("vec_latency", n, 3);
      chk("vec_data", out_data, {24'd0, tbl[k].exp});
      chk("vec_bmask", out_bmask, 4'h1);
      chk("vec_last", out_last, 1);
      chk("vec_idx", out_word_idx, 0);
      tick();
    end

    // four full lanes then a two-lane tail word closed by last
    cfg(0, -128, 127);
    got_q.delete();
    for (int j = 0; j < 6; j++) begin
      elem(j + 1, j == 5);
      in_valid = 1;
      tick();
      chk("pack_accept", accepted, 1);
    end
    in_valid = 0;
    n = 0;
    while (got_q.size() < 2 && n < 20) begin tick(); n++; end
    chk("pack_words", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("pack_w0_data", got_q[0].d, 32'h04030201);
      chk("pack_w0_bmask", got_q[0].m, 4'hf);
      chk("pack_w0_last", got_q[0].l, 0);
      chk("pack_w0_idx", got_q[0].i, 0);
      chk("pack_w1_data", got_q[1].d, 32'h00000605);
      chk("pack_w1_bmask", got_q[1].m, 4'h3);
      chk("pack_w1_last", got_q[1].l, 1);
      chk("pack_w1_idx", got_q[1].i, 1);
    end
    chk("pack_idx_back", out_word_idx, 0);
    chk("pack_busy", busy, 0);

    // backpressure: consumer stalls while eight elements are offered
    got_q.delete();
    out_ready = 0;
    i = 0; bad = 0; have = 0; stalled = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      elem(i + 1, i == 7);
      in_valid = i < 8;
      tick();
      if (accepted) i++;
      if (out_valid) begin
        if (!have) begin hold = out_data; have = 1; end
        else if (out_data !== hold) bad++;
      end
      if (!in_ready) stalled = 1;
    end
    chk("bp_stalled", stalled, 1);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_hold_stable", bad, 0);
    chk("bp_held_word", hold, 32'h04030201);
    out_ready = 1;
    n = 0;
    while (i < 8 && n < 40) begin
      elem(i + 1, i == 7);
      in_valid = 1;
      tick();
      if (accepted) i++;
      n++;
    end
    drain();
    chk("bp_words", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_w0", got_q[0].d, 32'h04030201);
      chk("bp_w1", got_q[1].d, 32'h08070605);
      chk("bp_w1_last", got_q[1].l, 1);
    end

    // clear while a partial word and a nonzero word index are live
    for (int j = 0; j < 6; j++) begin
      elem(j + 1, 1'b0);
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    n = 0;
    while (out_word_idx != 1 && n < 20) begin tick(); n++; end
    chk("clr_pre_idx", out_word_idx, 1);
    chk("clr_pre_busy", busy, 1);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_busy", busy, 0);
    chk("clr_idx", out_word_idx, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    base = got_q.size();
    for (int j = 0; j < 6; j++) tick();
    chk("clr_no_stray", got_q.size(), base);

    // randomized streams against the reference model
    for (int b = 0; b < 3; b++) begin
      if (b == 0) cfg(0, -128, 127);
      else if (b == 1) cfg(int'($urandom_range(0, 400)) - 200, -1000 + int'($urandom_range(0, 500)), int'($urandom_range(0, 1000)));
      else cfg(0, 32'h80000000, 32'h7fffffff);
      i = 0;
      n = 0;
      while (i < 120 && n < 3000) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_acc = $urandom_range(0, 1) ? $urandom : 32'(int'($urandom_range(0, 4000)) - 2000);
        in_bias = 32'(int'($urandom_range(0, 200)) - 100);
        in_mult = $urandom;
        in_shift = 6'(int'($urandom_range(0, 62)) - 31);
        in_last = i == 119 || $urandom_range(0, 7) == 0;
        out_ready = $urandom_range(0, 3) != 0;
        tick();
        if (accepted) i++;
        n++;
      end
      chk("rnd_all_accepted", i, 120);
      drain();
      chk("rnd_exp_empty", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
